mdu_sched: RTL and testbench

//   Sequencer for the HI/LO multiply/divide unit. Accepts one decoded MDU op (oper_t) per

---
 rtl/mdu_sched_if.sv | 23 ++
 rtl/mdu_sched.sv | 208 ++++++++++++++++++++
 tb/tb_mdu_sched.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_sched_if.sv
// Request/response bundle between EX and the HI/LO multiply/divide sequencer.
interface mdu_sched_if;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  op;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic        busy;
  logic        resp_valid;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output req_valid, op, reg1, reg2,
    input  req_ready, busy, resp_valid, result, hi, lo
  );

  modport slave (
    input  req_valid, op, reg1, reg2,
    output req_ready, busy, resp_valid, result, hi, lo
  );
endinterface

// File: rtl/mdu_sched.sv
// HI/LO multiply/divide sequencer: pipelined multiplier, 32-step restoring divider, HI/LO owner.
// Optional macro MDU_DIV_EARLY_TERM_EN enables early exit for trivial divides.
module mdu_sched #(
  parameter int unsigned MUL_LAT = 2
) (
  input logic       clk,
  input logic       rst_n,
  input logic       flush,
  mdu_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_WAIT,
    S_DIV_RUN,
    S_DIV_FIX,
    S_COMMIT
  } state_e;

  typedef enum logic [6:0] {
    OP_MULT  = 7'h01,
    OP_MULTU = 7'h02,
    OP_MADD  = 7'h03,
    OP_MADDU = 7'h04,
    OP_MSUB  = 7'h05,
    OP_MSUBU = 7'h06,
    OP_MUL   = 7'h07,
    OP_DIV   = 7'h08,
    OP_DIVU  = 7'h09,
    OP_MTHI  = 7'h0A,
    OP_MTLO  = 7'h0B
  } oper_e;

  state_e      r_state;
  state_e      w_next;
  logic [6:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [5:0]  r_cnt;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_dvs;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [63:0] r_pipe [MUL_LAT];
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_result;
  logic        r_resp_valid;

  logic        w_accept;
  logic        w_in_mul;
  logic        w_in_div;
  logic        w_in_sdiv;
  logic        w_in_neg_q;
  logic        w_in_neg_r;
  logic [31:0] w_dvd_mag;
  logic [31:0] w_dvs_mag;
  logic        w_early;
  logic [31:0] w_early_quo;
  logic        w_mul_signed;
  logic [63:0] w_ma;
  logic [63:0] w_mb;
  logic [63:0] w_prod;
  logic [63:0] w_acc;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_diff;

  assign bus.req_ready  = (r_state == S_IDLE) & ~flush;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.resp_valid = r_resp_valid;
  assign bus.result     = r_result;
  assign bus.hi         = r_hi;
  assign bus.lo         = r_lo;

  assign w_accept   = bus.req_valid & bus.req_ready;
  assign w_in_mul   = bus.op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_MUL};
  assign w_in_div   = bus.op inside {OP_DIV, OP_DIVU};
  assign w_in_sdiv  = (bus.op == OP_DIV);
  assign w_in_neg_q = w_in_sdiv & (bus.reg1[31] ^ bus.reg2[31]);
  assign w_in_neg_r = w_in_sdiv & bus.reg1[31];
  assign w_dvd_mag  = (w_in_sdiv & bus.reg1[31]) ? 32'd0 - bus.reg1 : bus.reg1;
  assign w_dvs_mag  = (w_in_sdiv & bus.reg2[31]) ? 32'd0 - bus.reg2 : bus.reg2;

`ifdef MDU_DIV_EARLY_TERM_EN
  // Early-exit quotient already carries the sign fix the full path would apply.
  assign w_early     = w_in_div & ((w_dvs_mag == '0) | (w_dvd_mag < w_dvs_mag));
  assign w_early_quo = (w_dvs_mag == '0) ? (w_in_neg_q ? 32'd1 : '1) : '0;
`else
  assign w_early     = 1'b0;
  assign w_early_quo = '0;
`endif

  assign w_mul_signed = r_op inside {OP_MULT, OP_MADD, OP_MSUB, OP_MUL};
  assign w_ma   = {{32{w_mul_signed & r_a[31]}}, r_a};
  assign w_mb   = {{32{w_mul_signed & r_b[31]}}, r_b};
  assign w_prod = w_ma * w_mb;
  assign w_acc  = {r_hi, r_lo};

  assign w_shift = {r_rem, r_quo[31]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_diff  = w_shift[31:0] - r_dvs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_in_mul)                 w_next = S_MUL_WAIT;
          else if (w_in_div & ~w_early) w_next = S_DIV_RUN;
          else                          w_next = S_COMMIT;
        end
      end
      S_MUL_WAIT: if (r_cnt == 6'(MUL_LAT - 1)) w_next = S_COMMIT;
      S_DIV_RUN:  if (r_cnt == 6'd31)           w_next = S_DIV_FIX;
      S_DIV_FIX:  w_next = S_COMMIT;
      S_COMMIT:   w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_cnt        <= '0;
      r_quo        <= '0;
      r_rem        <= '0;
      r_dvs        <= '0;
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
      r_hi         <= '0;
      r_lo         <= '0;
      r_result     <= '0;
      r_resp_valid <= 1'b0;
      for (int unsigned i = 0; i < MUL_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      // Product pipeline runs freely; operands are stable from accept until commit.
      r_pipe[0] <= w_prod;
      for (int unsigned i = 1; i < MUL_LAT; i++) r_pipe[i] <= r_pipe[i-1];

      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= bus.op;
            r_a     <= bus.reg1;
            r_b     <= bus.reg2;
            r_cnt   <= '0;
            r_neg_q <= w_in_neg_q;
            r_neg_r <= w_in_neg_r;
            r_dvs   <= w_dvs_mag;
            if (w_early) begin
              r_quo <= w_early_quo;
              r_rem <= bus.reg1;
            end else begin
              r_quo <= w_dvd_mag;
              r_rem <= '0;
            end
          end
        end
        S_MUL_WAIT: r_cnt <= r_cnt + 6'd1;
        S_DIV_RUN: begin
          r_cnt <= r_cnt + 6'd1;
          if (w_ge) begin
            r_rem <= w_diff;
            r_quo <= {r_quo[30:0], 1'b1};
          end else begin
            r_rem <= w_shift[31:0];
            r_quo <= {r_quo[30:0], 1'b0};
          end
        end
        S_DIV_FIX: begin
          if (r_neg_q) r_quo <= 32'd0 - r_quo;
          if (r_neg_r) r_rem <= 32'd0 - r_rem;
        end
        S_COMMIT: begin
          if (!flush) begin
            r_resp_valid <= 1'b1;
            case (r_op)
              OP_MULT, OP_MULTU: {r_hi, r_lo} <= r_pipe[MUL_LAT-1];
              OP_MADD, OP_MADDU: {r_hi, r_lo} <= w_acc + r_pipe[MUL_LAT-1];
              OP_MSUB, OP_MSUBU: {r_hi, r_lo} <= w_acc - r_pipe[MUL_LAT-1];
              OP_MUL:            r_result     <= r_pipe[MUL_LAT-1][31:0];
              OP_DIV, OP_DIVU: begin
                r_hi <= r_rem;
                r_lo <= r_quo;
              end
              OP_MTHI: r_hi <= r_a;
              OP_MTLO: r_lo <= r_a;
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sched.sv
// Scoreboard bench for mdu_sched: random and directed ops against an arithmetic reference model.
module tb_mdu_sched;
  localparam int unsigned MUL_LAT = 2;

  localparam logic [6:0] MULT  = 7'h01, MULTU = 7'h02, MADD  = 7'h03, MADDU = 7'h04;
  localparam logic [6:0] MSUB  = 7'h05, MSUBU = 7'h06, MUL   = 7'h07, DIV   = 7'h08;
  localparam logic [6:0] DIVU  = 7'h09, MTHI  = 7'h0A, MTLO  = 7'h0B, OTHER = 7'h7F;

  typedef struct {
    int          c0;
    int          lat;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [31:0] m_hi = '0, m_lo = '0, m_result = '0;
  logic [6:0] codes [12] = '{MULT, MULTU, MADD, MADDU, MSUB, MSUBU, MUL, DIV, DIVU, MTHI, MTLO, OTHER};

  mdu_sched_if ifc();

  mdu_sched #(.MUL_LAT(MUL_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b, output exp_t e);
    logic [63:0] acc, ps, pu;
    logic        sgn, na, nb;
    logic [31:0] ma, mb, mq, mr;
    acc = {m_hi, m_lo};
    ps  = 64'(longint'($signed(a)) * longint'($signed(b)));
    pu  = {32'd0, a} * {32'd0, b};
    e.lat = 2;
    case (op)
      MULT:  begin acc = ps;       e.lat = MUL_LAT + 2; end
      MULTU: begin acc = pu;       e.lat = MUL_LAT + 2; end
      MADD:  begin acc = acc + ps; e.lat = MUL_LAT + 2; end
      MADDU: begin acc = acc + pu; e.lat = MUL_LAT + 2; end
      MSUB:  begin acc = acc - ps; e.lat = MUL_LAT + 2; end
      MSUBU: begin acc = acc - pu; e.lat = MUL_LAT + 2; end
      MUL:   begin m_result = ps[31:0]; e.lat = MUL_LAT + 2; end
      DIV, DIVU: begin
        sgn = (op == DIV);
        na  = sgn & a[31];
        nb  = sgn & b[31];
        ma  = na ? -a : a;
        mb  = nb ? -b : b;
        if (mb == 0) begin
          mq = 32'hFFFFFFFF;
          mr = ma;
        end else begin
          mq = ma / mb;
          mr = ma % mb;
        end
        acc = {(na ? -mr : mr), ((na ^ nb) ? -mq : mq)};
        e.lat = 35;
`ifdef MDU_DIV_EARLY_TERM_EN
        if (mb == 0 || ma < mb) e.lat = 2;
`endif
      end
      MTHI: acc[63:32] = a;
      MTLO: acc[31:0]  = a;
      default: ;
    endcase
    m_hi  = acc[63:32];
    m_lo  = acc[31:0];
    e.res = m_result;
    e.hi  = m_hi;
    e.lo  = m_lo;
    e.c0  = 0;
  endtask

  // Called at a negedge; returns one negedge after the accept cycle.
  task automatic issue(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t e;
    int unsigned n;
    n = 0;
    ifc.op = op;
    ifc.reg1 = a;
    ifc.reg2 = b;
    ifc.req_valid = 1'b1;
    while (!ifc.req_ready && n < 200) begin
      if (!flush) chk("busy_while_held", 64'(ifc.busy), 64'd1);
      @(negedge clk);
      n++;
    end
    if (!ifc.req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=req_ready_low required=accept_within_200");
    end else if (push) begin
      model(op, a, b, e);
      e.c0 = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    ifc.req_valid = 1'b0;
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom_range(0, 20);
      4: return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && ifc.resp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_resp actual=resp_valid_1 required=no_pending_op (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency", 64'(cyc - e.c0), 64'(e.lat));
        chk("result", 64'(ifc.result), 64'(e.res));
        chk("hi", 64'(ifc.hi), 64'(e.hi));
        chk("lo", 64'(ifc.lo), 64'(e.lo));
      end
    end
  end

  initial begin
    #5ms;
    errors++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    ifc.req_valid = 1'b0;
    ifc.op = '0;
    ifc.reg1 = '0;
    ifc.reg2 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(ifc.req_ready), 64'd1);
    chk("rst_busy", 64'(ifc.busy), 64'd0);
    chk("rst_resp", 64'(ifc.resp_valid), 64'd0);
    chk("rst_hilo", {ifc.hi, ifc.lo}, 64'd0);
    chk("rst_result", 64'(ifc.result), 64'd0);

    issue(MULT, -32'sd3, 32'd5, 1);
    issue(MTHI, 32'd1, 32'd0, 1);
    issue(MTLO, 32'hFFFFFFFF, 32'd0, 1);
    issue(MADDU, 32'd1, 32'd1, 1);
    issue(MSUB, 32'd1, 32'd1, 1);
    issue(DIV, -32'sd7, 32'd2, 1);
    issue(DIVU, 32'd7, 32'd0, 1);
    issue(DIVU, 32'd3, 32'd9, 1);
    issue(DIV, 32'h80000000, 32'hFFFFFFFF, 1);
    issue(DIV, -32'sd7, 32'd0, 1);
    issue(MTHI, 32'h1234, 32'd0, 1);
    issue(MTLO, 32'h1234, 32'd0, 1);
    issue(MUL, 32'd6, 32'd7, 1);
    issue(OTHER, 32'hDEAD, 32'hBEEF, 1);

    // Flush mid-divide
    issue(DIV, 32'd100, 32'd3, 0);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_ready_low", 64'(ifc.req_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_idle_busy", 64'(ifc.busy), 64'd0);
    chk("flush_idle_ready", 64'(ifc.req_ready), 64'd1);
    repeat (40) @(negedge clk);
    chk("flush_hilo_kept", {ifc.hi, ifc.lo}, {m_hi, m_lo});

    // Flush while idle blocks a request
    flush = 1'b1;
    ifc.op = MTHI;
    ifc.reg1 = 32'hDEADBEEF;
    ifc.req_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_flush_busy", 64'(ifc.busy), 64'd0);
      chk("idle_flush_ready", 64'(ifc.req_ready), 64'd0);
    end
    ifc.req_valid = 1'b0;
    flush = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_flush_hi", 64'(ifc.hi), 64'(m_hi));

    // Async reset during divide
    issue(MTHI, 32'h5, 32'd0, 1);
    issue(MTLO, 32'h6, 32'd0, 1);
    issue(MUL, 32'd3, 32'd3, 1);
    repeat (6) @(negedge clk);
    issue(DIV, 32'd1000, 32'd7, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_hilo", {ifc.hi, ifc.lo}, 64'd0);
    chk("arst_result", 64'(ifc.result), 64'd0);
    chk("arst_busy", 64'(ifc.busy), 64'd0);
    chk("arst_resp", 64'(ifc.resp_valid), 64'd0);
    chk("arst_ready", 64'(ifc.req_ready), 64'd1);
    m_hi = '0;
    m_lo = '0;
    m_result = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(MADD, 32'd9, -32'sd2, 1);

    for (int k = 0; k < 200; k++) begin
      issue(codes[$urandom_range(0, 11)], rnd32(), rnd32(), 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    chk("drain_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
